mem_port_arbiter4: RTL and testbench

Round-robin arbiter that shares the single 32-bit memory port between four requesters (I-cache refill, D-cache refill/writeback, uncached load/store, debug/DMA). It picks one requester, holds it until the memory acknowledges, and drives the 2-bit select that steers the address and write-data 4:1 muxes. A watchdog aborts transactions the memory never acknowledges. Sits between the cache controllers and the memory/bus interface.

---
 rtl/arb_pkg.sv | 17 +
 rtl/mux4_32.sv | 20 ++
 rtl/rr_pick4.sv | 25 ++
 rtl/mem_port_arbiter4.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter4.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the four-way memory port arbiter: state encoding,
// requester indices and the default watchdog limit.
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int RQ_ICACHE   = 0;
    localparam int RQ_DCACHE   = 1;
    localparam int RQ_UNCACHED = 2;
    localparam int RQ_DEBUG    = 3;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mux4_32.sv
// 32-bit 4:1 multiplexer used to steer requester address and write data.
module mux4_32 (
    input  logic [1:0]  sel,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    output logic [31:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = in0;
            2'd1:    y = in1;
            2'd2:    y = in2;
            default: y = in3;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin pick over four requests, searching upward from
// the slot after the previous winner.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk from the farthest slot to the nearest so the nearest set bit wins.
    always_comb begin
        valid = |req;
        idx   = last;
        cand  = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter4.sv
// Round-robin arbiter sharing one memory port among four requesters, with a
// watchdog that aborts transactions the memory never acknowledges.
//
// state   | meaning
// ST_IDLE | no transaction; arbitrate among pending requests
// ST_BUSY | granted requester owns the port until mem_ack or timeout
module mem_port_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [3:0]  we,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] addr2,
    input  logic [31:0] addr3,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [31:0] wdata2,
    input  logic [31:0] wdata3,
    output logic [3:0]  ack,
    output logic [3:0]  err,
    output logic [31:0] rdata,
    output logic [1:0]  sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_we_q, mem_we_d;

    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic        busy;
    logic        tmo_hit;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign busy    = (state_q == ST_BUSY);
    // mem_ack wins over the watchdog when both land in the final cycle.
    assign tmo_hit = busy && !mem_ack && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        mem_we_d = mem_we_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d    = pick_idx;
                    mem_we_d = we[pick_idx];
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                end
            end
            default: begin
                if (mem_ack || tmo_hit) begin
                    last_d  = sel_q;
                    state_d = ST_IDLE;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    // Reset leaves last at 3 so requester 0 holds first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'd0;
            last_q   <= 2'd3;
            cnt_q    <= '0;
            mem_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            mem_we_q <= mem_we_d;
        end
    end

    always_comb begin
        ack   = '0;
        err   = '0;
        rdata = '0;
        if (busy && mem_ack) begin
            ack[sel_q] = 1'b1;
            rdata      = mem_rdata;
        end
        if (tmo_hit) begin
            err[sel_q] = 1'b1;
        end
    end

    assign sel     = sel_q;
    assign mem_req = busy;
    assign mem_we  = mem_we_q;

    mux4_32 u_addr_mux (
        .sel (sel_q),
        .in0 (addr0),
        .in1 (addr1),
        .in2 (addr2),
        .in3 (addr3),
        .y   (mem_addr)
    );

    mux4_32 u_wdata_mux (
        .sel (sel_q),
        .in0 (wdata0),
        .in1 (wdata1),
        .in2 (wdata2),
        .in3 (wdata3),
        .y   (mem_wdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter4.sv
// Bench for mem_port_arbiter4: vector tables, directed corner sequences and
// randomized traffic compared against a transaction-level reference model.
module tb_mem_port_arbiter4;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] addr_v [4];
    logic [31:0] wdata_v [4];
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [31:0] rdata;
    logic [1:0]  sel;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: who owns the port and for how many cycles.
    bit m_busy;
    int m_sel;
    int m_last;
    int m_cnt;
    bit m_we;

    mem_port_arbiter4 #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr0     (addr_v[0]),
        .addr1     (addr_v[1]),
        .addr2     (addr_v[2]),
        .addr3     (addr_v[3]),
        .wdata0    (wdata_v[0]),
        .wdata1    (wdata_v[1]),
        .wdata2    (wdata_v[2]),
        .wdata3    (wdata_v[3]),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .sel       (sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       mack;
        logic       exp_mreq;
        logic [1:0] exp_sel;
        logic [3:0] exp_ack;
    } vec_t;

    vec_t tbl[$];

    function automatic int rr_ref(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_sel  = 0;
        m_last = 3;
        m_cnt  = 0;
        m_we   = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Compare every output with the model for the inputs currently driven.
    task automatic check_now();
        logic [3:0]  e_ack;
        logic [3:0]  e_err;
        logic [31:0] e_rdata;
        #1;
        if (rst) model_reset();
        e_ack   = '0;
        e_err   = '0;
        e_rdata = '0;
        if (m_busy && mem_ack) begin
            e_ack[m_sel] = 1'b1;
            e_rdata      = mem_rdata;
        end else if (m_busy && m_cnt == TO) begin
            e_err[m_sel] = 1'b1;
        end
        chk("mem_req", 32'(mem_req), 32'(m_busy));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("err", 32'(err), 32'(e_err));
        chk("rdata", rdata, e_rdata);
        if (m_busy) begin
            chk("mem_addr", mem_addr, addr_v[m_sel]);
            chk("mem_wdata", mem_wdata, wdata_v[m_sel]);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            if (!m_busy) begin
                if (req != 4'b0000) begin
                    m_sel  = rr_ref(req, m_last);
                    m_we   = we[m_sel];
                    m_busy = 1'b1;
                    m_cnt  = 1;
                end
            end else if (mem_ack || m_cnt == TO) begin
                m_last = m_sel;
                m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        check_now();
        advance();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req     = '0;
        mem_ack = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic push_vec(input logic r, input logic [3:0] rq, input logic ma,
                            input logic emr, input logic [1:0] es, input logic [3:0] ea);
        vec_t v;
        v.rst = r; v.req = rq; v.mack = ma;
        v.exp_mreq = emr; v.exp_sel = es; v.exp_ack = ea;
        tbl.push_back(v);
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        we        = '0;
        mem_ack   = 1'b0;
        mem_rdata = 32'hA5A5_0000;
        for (int i = 0; i < 4; i++) begin
            addr_v[i]  = 32'h100 * (i + 1);
            wdata_v[i] = 32'hCAFE_0000 + 32'(i);
        end
        model_reset();

        // Round robin with all requesters pending and zero-wait memory.
        push_vec(1, 4'b0000, 1, 0, 0, 4'b0000);
        push_vec(0, 4'b1111, 1, 0, 0, 4'b0000);
        push_vec(0, 4'b1111, 1, 1, 0, 4'b0001);
        push_vec(0, 4'b1111, 1, 0, 0, 4'b0000);
        push_vec(0, 4'b1111, 1, 1, 1, 4'b0010);
        push_vec(0, 4'b1111, 1, 0, 1, 4'b0000);
        push_vec(0, 4'b1111, 1, 1, 2, 4'b0100);
        push_vec(0, 4'b1111, 1, 0, 2, 4'b0000);
        push_vec(0, 4'b1111, 1, 1, 3, 4'b1000);
        push_vec(0, 4'b1111, 1, 0, 3, 4'b0000);
        push_vec(0, 4'b1111, 1, 1, 0, 4'b0001);
        // Priority right after reset: 1 before 3, then back to 1.
        push_vec(1, 4'b0000, 0, 0, 0, 4'b0000);
        push_vec(0, 4'b1010, 1, 0, 0, 4'b0000);
        push_vec(0, 4'b1010, 1, 1, 1, 4'b0010);
        push_vec(0, 4'b1010, 1, 0, 1, 4'b0000);
        push_vec(0, 4'b1010, 1, 1, 3, 4'b1000);
        push_vec(0, 4'b1010, 1, 0, 3, 4'b0000);
        push_vec(0, 4'b1010, 1, 1, 1, 4'b0010);

        @(negedge clk);
        foreach (tbl[i]) begin
            rst     = tbl[i].rst;
            req     = tbl[i].req;
            mem_ack = tbl[i].mack;
            check_now();
            chk($sformatf("tbl%0d.mem_req", i), 32'(mem_req), 32'(tbl[i].exp_mreq));
            chk($sformatf("tbl%0d.sel", i), 32'(sel), 32'(tbl[i].exp_sel));
            chk($sformatf("tbl%0d.ack", i), 32'(ack), 32'(tbl[i].exp_ack));
            advance();
        end
        rst = 1'b0;

        // Single read, memory acks two cycles after mem_req rises.
        do_reset();
        addr_v[0] = 32'h0000_1000;
        we        = 4'b0000;
        req       = 4'b0001;
        cyc();
        cyc();
        cyc();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        check_now();
        chk("rd.ack", 32'(ack), 32'h1);
        chk("rd.rdata", rdata, 32'hDEAD_BEEF);
        chk("rd.addr", mem_addr, 32'h0000_1000);
        chk("rd.we", 32'(mem_we), 32'h0);
        advance();
        req     = 4'b0000;
        mem_ack = 1'b0;
        check_now();
        chk("rd.ack_once", 32'(ack), 32'h0);
        chk("rd.idle", 32'(mem_req), 32'h0);
        chk("rd.rdata_idle", rdata, 32'h0);
        advance();

        // Timeout on requester 2 with requester 3 waiting.
        do_reset();
        req = 4'b1100;
        for (int c = 0; c < 4; c++) cyc();
        check_now();
        chk("to.err", 32'(err), 32'b0100);
        chk("to.ack", 32'(ack), 32'h0);
        advance();
        req = 4'b1000;
        check_now();
        chk("to.mreq_drop", 32'(mem_req), 32'h0);
        advance();
        check_now();
        chk("to.next_sel", 32'(sel), 32'd3);
        chk("to.next_mreq", 32'(mem_req), 32'h1);
        advance();
        req = 4'b0000;
        for (int c = 0; c < 4; c++) cyc();

        // mem_ack in the final watchdog cycle wins.
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 4; c++) cyc();
        mem_ack = 1'b1;
        check_now();
        chk("race.ack", 32'(ack), 32'b0001);
        chk("race.err", 32'(err), 32'h0);
        advance();
        req     = 4'b0000;
        mem_ack = 1'b0;
        cyc();

        // Reset in the second BUSY cycle of a write.
        do_reset();
        we         = 4'b0001;
        wdata_v[0] = 32'h1234_5678;
        req        = 4'b0001;
        cyc();
        check_now();
        chk("wr.we", 32'(mem_we), 32'h1);
        chk("wr.wdata", mem_wdata, 32'h1234_5678);
        advance();
        rst = 1'b1;
        check_now();
        chk("rst.mreq", 32'(mem_req), 32'h0);
        chk("rst.ack", 32'(ack), 32'h0);
        chk("rst.err", 32'(err), 32'h0);
        chk("rst.sel", 32'(sel), 32'h0);
        advance();
        rst = 1'b0;
        req = 4'b1111;
        cyc();
        check_now();
        chk("rst.restart_sel", 32'(sel), 32'h0);
        advance();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req       = 4'($urandom_range(0, 15));
            we        = 4'($urandom_range(0, 15));
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            for (int i = 0; i < 4; i++) begin
                addr_v[i]  = $urandom;
                wdata_v[i] = $urandom;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
